// File: rtl/fir_pkg.sv
// Shared constants and state encoding for the coefficient-loaded Q1.15 FIR filter.
// Defaults here seed the top-level parameters; rounding constants assume Q1.15 data.
package fir_pkg;

  localparam int FIR_NUM_TAPS = 62;
  localparam int FIR_DATA_W   = 16;
  localparam int FIR_ACC_W    = 40;

  localparam int ROUND_SHIFT  = 15;
  localparam int ROUND_BIAS   = 1 << 14;
  localparam int SAT_MAX      = 32767;
  localparam int SAT_MIN      = -32768;

  typedef enum logic [2:0] {
    ST_LOAD,
    ST_IDLE,
    ST_MAC,
    ST_ROUND,
    ST_OUT
  } fir_state_e;

endpackage

// File: rtl/fir_tap_ram.sv
// Coefficient store: one write port and one registered read port (block-RAM style).
// Contents are not reset; the loader rewrites every tap after each reset.
module fir_tap_ram import fir_pkg::*; #(
  parameter int DEPTH  = FIR_NUM_TAPS,
  parameter int WIDTH  = FIR_DATA_W,
  parameter int ADDR_W = $clog2(FIR_NUM_TAPS)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data_q <= mem[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/fir_coef_reader.sv
// Single-MAC FIR: loads coefficients, then for each accepted sample runs one tap per
// cycle over a circular delay line, rounds/saturates to Q1.15 and pulses out_valid.
module fir_coef_reader import fir_pkg::*; #(
  parameter int NUM_TAPS = FIR_NUM_TAPS,
  parameter int DATA_W   = FIR_DATA_W,
  parameter int ACC_W    = FIR_ACC_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              coef_wren,
  input  logic [6:0]        coef_addr,
  input  logic [DATA_W-1:0] coef_data,
  input  logic              load_done,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] filter_in,
  output logic              sample_ready,
  output logic [DATA_W-1:0] filter_out,
  output logic              out_valid,
  output logic              busy
);

  localparam int IDX_W  = $clog2(NUM_TAPS);
  localparam int PROD_W = 2 * DATA_W;

  localparam logic [IDX_W-1:0]        LAST_TAP   = IDX_W'(NUM_TAPS - 1);
  localparam logic [IDX_W:0]          TAPS_WIDE  = (IDX_W + 1)'(NUM_TAPS);
  localparam logic signed [ACC_W-1:0] BIAS       = ACC_W'(ROUND_BIAS);
  localparam logic signed [ACC_W-1:0] SAT_HI     = ACC_W'(SAT_MAX);
  localparam logic signed [ACC_W-1:0] SAT_LO     = ACC_W'(SAT_MIN);
  localparam logic [DATA_W-1:0]       SAT_HI_OUT = DATA_W'(SAT_MAX);
  localparam logic [DATA_W-1:0]       SAT_LO_OUT = DATA_W'(SAT_MIN);

  fir_state_e               state_q, state_d;
  logic [IDX_W-1:0]         tap_q, tap_d;
  logic [IDX_W-1:0]         wr_ptr_q, wr_ptr_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [DATA_W-1:0]        round_q, round_d;
  logic [DATA_W-1:0]        filter_out_q, filter_out_d;
  logic                     out_valid_q, out_valid_d;
  logic                     sample_ready_q, sample_ready_d;
  logic                     busy_q, busy_d;

  logic                     addr_in_range;
  logic                     ram_we;
  logic                     dly_we;
  logic [IDX_W-1:0]         ram_raddr;
  logic [DATA_W-1:0]        coef_rd;
  logic [IDX_W-1:0]         rd_idx;
  logic [DATA_W-1:0]        dly_q [NUM_TAPS];
  logic [DATA_W-1:0]        tap_sample;
  logic signed [PROD_W-1:0] product;
  logic signed [ACC_W-1:0]  product_ext;
  logic signed [ACC_W-1:0]  acc_rnd;
  logic signed [ACC_W-1:0]  acc_shift;
  logic [DATA_W-1:0]        sat_val;

  assign addr_in_range = (32'(coef_addr) < NUM_TAPS);

  fir_tap_ram #(
    .DEPTH  (NUM_TAPS),
    .WIDTH  (DATA_W),
    .ADDR_W (IDX_W)
  ) u_tap_ram (
    .clk     (clk),
    .wr_en   (ram_we),
    .wr_addr (coef_addr[IDX_W-1:0]),
    .wr_data (coef_data),
    .rd_addr (ram_raddr),
    .rd_data (coef_rd)
  );

  // Delay line cells; only the slot under wr_ptr takes the accepted sample.
  for (genvar gi = 0; gi < NUM_TAPS; gi++) begin : g_dly
    logic [DATA_W-1:0] cell_q;
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        cell_q <= '0;
      end else if (dly_we && (wr_ptr_q == IDX_W'(gi))) begin
        cell_q <= filter_in;
      end
    end
    assign dly_q[gi] = cell_q;
  end

  always_comb begin
    if (wr_ptr_q >= tap_q) begin
      rd_idx = wr_ptr_q - tap_q;
    end else begin
      rd_idx = IDX_W'(TAPS_WIDE + {1'b0, wr_ptr_q} - {1'b0, tap_q});
    end
  end

  assign tap_sample  = dly_q[rd_idx];
  assign product     = $signed(coef_rd) * $signed(tap_sample);
  assign product_ext = ACC_W'(product);
  assign acc_rnd     = acc_q + BIAS;
  assign acc_shift   = acc_rnd >>> ROUND_SHIFT;

  always_comb begin
    if (acc_shift > SAT_HI) begin
      sat_val = SAT_HI_OUT;
    end else if (acc_shift < SAT_LO) begin
      sat_val = SAT_LO_OUT;
    end else begin
      sat_val = acc_shift[DATA_W-1:0];
    end
  end

  // The RAM read for tap k+1 is issued while tap k is accumulated; IDLE
  // pre-reads tap 0 so the first MAC cycle already sees coef[0].
  always_comb begin
    state_d      = state_q;
    tap_d        = tap_q;
    wr_ptr_d     = wr_ptr_q;
    acc_d        = acc_q;
    round_d      = round_q;
    filter_out_d = filter_out_q;
    out_valid_d  = 1'b0;
    ram_we       = 1'b0;
    dly_we       = 1'b0;
    ram_raddr    = '0;
    case (state_q)
      ST_LOAD: begin
        ram_we = coef_wren && addr_in_range;
        if (load_done) begin
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (sample_valid) begin
          dly_we  = 1'b1;
          acc_d   = '0;
          tap_d   = '0;
          state_d = ST_MAC;
        end
      end
      ST_MAC: begin
        acc_d = acc_q + product_ext;
        if (tap_q == LAST_TAP) begin
          state_d = ST_ROUND;
        end else begin
          tap_d     = tap_q + 1'b1;
          ram_raddr = tap_q + 1'b1;
        end
      end
      ST_ROUND: begin
        round_d = sat_val;
        state_d = ST_OUT;
      end
      ST_OUT: begin
        filter_out_d = round_q;
        out_valid_d  = 1'b1;
        wr_ptr_d     = (wr_ptr_q == LAST_TAP) ? '0 : wr_ptr_q + 1'b1;
        state_d      = ST_IDLE;
      end
      default: begin
        state_d = ST_LOAD;
      end
    endcase
    sample_ready_d = (state_d == ST_IDLE);
    busy_d         = (state_d == ST_MAC) || (state_d == ST_ROUND);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_LOAD;
      tap_q          <= '0;
      wr_ptr_q       <= '0;
      acc_q          <= '0;
      round_q        <= '0;
      filter_out_q   <= '0;
      out_valid_q    <= 1'b0;
      sample_ready_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      tap_q          <= tap_d;
      wr_ptr_q       <= wr_ptr_d;
      acc_q          <= acc_d;
      round_q        <= round_d;
      filter_out_q   <= filter_out_d;
      out_valid_q    <= out_valid_d;
      sample_ready_q <= sample_ready_d;
      busy_q         <= busy_d;
    end
  end

  assign sample_ready = sample_ready_q;
  assign filter_out   = filter_out_q;
  assign out_valid    = out_valid_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_fir_coef_reader.sv
// Directed bench for fir_coef_reader: impulse, step, saturation, load guards,
// reset during MAC and back-to-back offered samples with delay-line wrap.
module tb_fir_coef_reader;

  localparam int N = 62;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        coef_wren = 1'b0;
  logic [6:0]  coef_addr = '0;
  logic [15:0] coef_data = '0;
  logic        load_done = 1'b0;
  logic        sample_valid = 1'b0;
  logic [15:0] filter_in = '0;
  logic        sample_ready;
  logic [15:0] filter_out;
  logic        out_valid;
  logic        busy;

  int total = 0;
  int bad = 0;
  logic [15:0] coef_tb [N];

  always #5 clk = ~clk;

  fir_coef_reader #(.NUM_TAPS(N), .DATA_W(16), .ACC_W(40)) dut (
    .clk          (clk),
    .reset        (reset),
    .coef_wren    (coef_wren),
    .coef_addr    (coef_addr),
    .coef_data    (coef_data),
    .load_done    (load_done),
    .sample_valid (sample_valid),
    .filter_in    (filter_in),
    .sample_ready (sample_ready),
    .filter_out   (filter_out),
    .out_valid    (out_valid),
    .busy         (busy)
  );

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    coef_wren = 1'b0;
    load_done = 1'b0;
    sample_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  // Writes coef_tb; the last tap is written in the same cycle as load_done.
  task automatic load_all(input bit inject_bad);
    for (int k = 0; k < N - 1; k++) begin
      coef_wren = 1'b1; coef_addr = 7'(k); coef_data = coef_tb[k];
      @(negedge clk);
    end
    if (inject_bad) begin
      coef_addr = 7'd62;  coef_data = 16'h7FFF; @(negedge clk);
      coef_addr = 7'd64;  coef_data = 16'h7FFF; @(negedge clk);
      coef_addr = 7'd100; coef_data = 16'h7FFF; @(negedge clk);
    end
    coef_addr = 7'(N - 1); coef_data = coef_tb[N-1]; load_done = 1'b1;
    @(negedge clk);
    coef_wren = 1'b0; load_done = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_sample(input logic [15:0] x, output logic [15:0] y,
                            output int lat, output bit ok);
    int n;
    ok = 1'b0; y = '0; lat = 0; n = 0;
    while (!sample_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sample_ready) begin
      sample_valid = 1'b1;
      filter_in = x;
      @(negedge clk);
      sample_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 200) begin
        @(negedge clk);
        n++;
      end
      if (out_valid) begin
        y = filter_out;
        lat = n;
        ok = 1'b1;
      end
    end
    $display("txn in=%h out=%h lat=%0d ok=%0d", x, y, lat, ok);
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (sample_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b want=0", sample_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (filter_out !== 16'h0000) begin bad++; $display("FAIL reset_filter_out got=%h want=0000", filter_out); end
  endtask

  task automatic test_load_guard();
    int ready_seen = 0;
    int ov_seen = 0;
    sample_valid = 1'b1;
    filter_in = 16'h7FFF;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (sample_ready) ready_seen++;
      if (out_valid) ov_seen++;
    end
    sample_valid = 1'b0;
    total++; if (ready_seen !== 0) begin bad++; $display("FAIL guard_ready cycles_high=%0d want=0", ready_seen); end
    total++; if (ov_seen !== 0) begin bad++; $display("FAIL guard_out_valid pulses=%0d want=0", ov_seen); end
  endtask

  task automatic test_impulse();
    logic [15:0] y, expv;
    int lat;
    bit ok;
    for (int k = 0; k < N; k++) coef_tb[k] = 16'h2000;
    load_all(1'b1);
    // Write attempted in IDLE must not land.
    coef_wren = 1'b1; coef_addr = 7'd5; coef_data = 16'h7FFF;
    @(negedge clk);
    coef_wren = 1'b0;
    for (int n = 0; n < N + 2; n++) begin
      run_sample((n == 0) ? 16'h4000 : 16'h0000, y, lat, ok);
      expv = (n < N) ? 16'h1000 : 16'h0000;
      total++;
      if (!ok) begin bad++; $display("FAIL impulse[%0d] timeout got=none want=%h", n, expv); end
      else if (y !== expv) begin bad++; $display("FAIL impulse[%0d] got=%h want=%h", n, y, expv); end
      if (n == 0) begin
        total++; if (lat !== N + 2) begin bad++; $display("FAIL latency got=%0d want=%0d", lat, N + 2); end
        @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL out_valid_pulse got=%b want=0", out_valid); end
        repeat (4) @(negedge clk);
        total++; if (filter_out !== 16'h1000) begin bad++; $display("FAIL hold_filter_out got=%h want=1000", filter_out); end
      end
    end
  endtask

  task automatic test_step();
    logic [15:0] y;
    int lat;
    bit ok;
    logic [15:0] xs [6] = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h0001, 16'h7FFF};
    logic [15:0] es [6] = '{16'h7FFE, 16'h7FFE, 16'h7FFE, 16'h7FFE, 16'h0001, 16'h7FFE};
    do_reset();
    for (int k = 0; k < N; k++) coef_tb[k] = 16'h0000;
    coef_tb[0] = 16'h7FFF;
    load_all(1'b0);
    for (int i = 0; i < 6; i++) begin
      run_sample(xs[i], y, lat, ok);
      total++;
      if (!ok) begin bad++; $display("FAIL step[%0d] timeout got=none want=%h", i, es[i]); end
      else if (y !== es[i]) begin bad++; $display("FAIL step[%0d] got=%h want=%h", i, y, es[i]); end
    end
  endtask

  task automatic test_saturate();
    logic [15:0] y;
    int lat;
    bit ok;
    do_reset();
    for (int k = 0; k < N; k++) coef_tb[k] = 16'h7FFF;
    load_all(1'b0);
    for (int m = 1; m <= N; m++) begin
      run_sample(16'h7FFF, y, lat, ok);
      total++;
      if (!ok) begin bad++; $display("FAIL sat_pos[%0d] timeout", m); end
      else if (y !== ((m == 1) ? 16'h7FFE : 16'h7FFF)) begin
        bad++; $display("FAIL sat_pos[%0d] got=%h want=%h", m, y, (m == 1) ? 16'h7FFE : 16'h7FFF);
      end
    end
    // Window with 31 negative and 31 positive samples lands at -31; from 32 on it clips.
    for (int j = 1; j <= N; j++) begin
      run_sample(16'h8000, y, lat, ok);
      if (j >= 31) begin
        total++;
        if (!ok) begin bad++; $display("FAIL sat_neg[%0d] timeout", j); end
        else if (y !== ((j == 31) ? 16'hFFE1 : 16'h8000)) begin
          bad++; $display("FAIL sat_neg[%0d] got=%h want=%h", j, y, (j == 31) ? 16'hFFE1 : 16'h8000);
        end
      end
    end
  endtask

  task automatic test_reset_in_mac();
    int ready_seen = 0;
    int ov_seen = 0;
    sample_valid = 1'b1;
    filter_in = 16'h1234;
    @(negedge clk);
    sample_valid = 1'b0;
    repeat (9) @(negedge clk);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL mac_busy got=%b want=1", busy); end
    reset = 1'b0;
    #1;
    total++; if (filter_out !== 16'h0000) begin bad++; $display("FAIL abort_filter_out got=%h want=0000", filter_out); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b want=0", busy); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL abort_out_valid got=%b want=0", out_valid); end
    total++; if (sample_ready !== 1'b0) begin bad++; $display("FAIL abort_ready got=%b want=0", sample_ready); end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    sample_valid = 1'b1;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (sample_ready) ready_seen++;
      if (out_valid) ov_seen++;
    end
    sample_valid = 1'b0;
    total++; if (ov_seen !== 0) begin bad++; $display("FAIL abort_no_output pulses=%0d want=0", ov_seen); end
    total++; if (ready_seen !== 0) begin bad++; $display("FAIL abort_in_load ready_cycles=%0d want=0", ready_seen); end
  endtask

  task automatic test_back_to_back();
    localparam int S = 70;
    int acc_cnt = 0;
    int out_cnt = 0;
    int cyc = 0;
    int acc_edge [S];
    int expv;
    do_reset();
    for (int k = 0; k < N; k++) coef_tb[k] = 16'h0000;
    coef_tb[0]   = 16'h4000;
    coef_tb[1]   = 16'h2000;
    coef_tb[N-1] = 16'h1000;
    load_all(1'b0);
    // Edge e is the rising edge just before negedge number e.
    while ((acc_cnt < S || out_cnt < S) && cyc < S * (N + 3) + 300) begin
      sample_valid = (acc_cnt < S);
      filter_in = 16'((acc_cnt + 1) * 256);
      if (out_valid && out_cnt < S) begin
        expv = 128 * (out_cnt + 1) + 64 * out_cnt + ((out_cnt + 1 >= N) ? 32 * (out_cnt + 2 - N) : 0);
        total++;
        if (filter_out !== 16'(expv)) begin bad++; $display("FAIL b2b_out[%0d] got=%h want=%h", out_cnt + 1, filter_out, 16'(expv)); end
        total++;
        if (cyc - acc_edge[out_cnt] !== N + 2) begin bad++; $display("FAIL b2b_latency[%0d] got=%0d want=%0d", out_cnt + 1, cyc - acc_edge[out_cnt], N + 2); end
        $display("txn b2b out[%0d]=%h", out_cnt + 1, filter_out);
        out_cnt++;
      end
      if (sample_ready && sample_valid) begin
        acc_edge[acc_cnt] = cyc + 1;
        if (acc_cnt > 0) begin
          total++;
          if (acc_edge[acc_cnt] - acc_edge[acc_cnt-1] !== N + 3) begin
            bad++; $display("FAIL b2b_spacing[%0d] got=%0d want=%0d", acc_cnt, acc_edge[acc_cnt] - acc_edge[acc_cnt-1], N + 3);
          end
        end
        acc_cnt++;
      end
      @(negedge clk);
      cyc++;
    end
    sample_valid = 1'b0;
    total++;
    if (acc_cnt !== S || out_cnt !== S) begin
      bad++; $display("FAIL b2b_timeout accepted=%0d outputs=%0d want=%0d", acc_cnt, out_cnt, S);
    end
  endtask

  initial begin
    test_reset();
    test_load_guard();
    test_impulse();
    test_step();
    test_saturate();
    test_reset_in_mac();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
